// File: rtl/carfield_cdc_pkg.sv
// Shared helpers for the Carfield gray-pointer CDC FIFO halves.
// Pointer codecs work on zero-extended values up to 32 bits wide.
package carfield_cdc_pkg;

    localparam int unsigned CdcDefaultSyncStages = 2;
    localparam int unsigned CdcMaxPtrWidth       = 32;

    function automatic logic [CdcMaxPtrWidth-1:0] bin2gray(
        input logic [CdcMaxPtrWidth-1:0] bin
    );
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [CdcMaxPtrWidth-1:0] gray2bin(
        input logic [CdcMaxPtrWidth-1:0] gray,
        input int unsigned               width
    );
        logic [CdcMaxPtrWidth-1:0] bin;
        logic [CdcMaxPtrWidth-1:0] mask;
        bin = gray;
        for (int i = 1; i < CdcMaxPtrWidth; i++) begin
            bin = bin ^ (gray >> i);
        end
        mask = (width >= CdcMaxPtrWidth) ? '1 : ((CdcMaxPtrWidth'(1) << width) - 1'b1);
        return bin & mask;
    endfunction

endpackage

// File: rtl/carfield_cdc_ptr_sync.sv
// Multi-flop synchroniser for a gray-coded pointer crossing into this clock domain.
// The input goes straight into the first flop; the chain carries async_reg for CDC constraints.
module carfield_cdc_ptr_sync #(
    parameter int unsigned Width      = 4,
    parameter int unsigned SyncStages = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] async_i,
    output logic [Width-1:0] sync_o
);

    (* async_reg = "true" *) logic [SyncStages-1:0][Width-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], async_i};
        end
    end

    assign sync_o = sync_q[SyncStages-1];

endmodule

// File: rtl/carfield_llc_cdc_dst_channel.sv
// Read half of one gray-pointer async FIFO channel on the LLC/DRAM link: syncs the
// write pointer, pops entries in order into a registered valid/ready output stage.
module carfield_llc_cdc_dst_channel
    import carfield_cdc_pkg::*;
#(
    parameter int unsigned DataWidth  = 64,
    parameter int unsigned LogDepth   = 3,
    parameter int unsigned SyncStages = CdcDefaultSyncStages
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [(2**LogDepth)*DataWidth-1:0]  async_data_i,
    input  logic [LogDepth:0]                   async_wptr_i,
    output logic [LogDepth:0]                   async_rptr_o,
    output logic [DataWidth-1:0]                dst_data_o,
    output logic                                dst_valid_o,
    input  logic                                dst_ready_i,
    output logic                                empty_o
);

    localparam int unsigned PtrWidth = LogDepth + 1;
    localparam int unsigned Depth    = 2**LogDepth;

    logic [PtrWidth-1:0]  wptr_sync;
    logic [PtrWidth-1:0]  rptr_bin_q, rptr_bin_d;
    logic [PtrWidth-1:0]  rptr_gray_q, rptr_gray_d;
    logic [DataWidth-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 empty;
    logic                 load;
    logic [LogDepth-1:0]  rd_idx;
    logic [DataWidth-1:0] entries [Depth];

    for (genvar k = 0; k < Depth; k++) begin : g_entry
        assign entries[k] = async_data_i[k*DataWidth +: DataWidth];
    end

    carfield_cdc_ptr_sync #(
        .Width      (PtrWidth),
        .SyncStages (SyncStages)
    ) i_wptr_sync (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .async_i (async_wptr_i),
        .sync_o  (wptr_sync)
    );

    // rptr_gray_q always holds the gray form of rptr_bin_q, so it doubles as the empty comparand.
    assign empty  = (wptr_sync == rptr_gray_q);
    assign load   = !empty && (!valid_q || dst_ready_i);
    assign rd_idx = rptr_bin_q[LogDepth-1:0];

    always_comb begin
        rptr_bin_d = rptr_bin_q;
        data_d     = data_q;
        valid_d    = valid_q;
        if (load) begin
            rptr_bin_d = rptr_bin_q + 1'b1;
            data_d     = entries[rd_idx];
            valid_d    = 1'b1;
        end else if (dst_ready_i) begin
            valid_d    = 1'b0;
        end
        rptr_gray_d = PtrWidth'(bin2gray(CdcMaxPtrWidth'(rptr_bin_d)));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rptr_bin_q  <= '0;
            rptr_gray_q <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
        end else begin
            rptr_bin_q  <= rptr_bin_d;
            rptr_gray_q <= rptr_gray_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
        end
    end

    assign async_rptr_o = rptr_gray_q;
    assign dst_data_o   = data_q;
    assign dst_valid_o  = valid_q;
    assign empty_o      = empty;

endmodule

// File: tb/tb_carfield_llc_cdc_dst_channel.sv
// Directed bench for the destination half of the LLC CDC FIFO, with a behavioural source half.
`timescale 1ns/1ps
module tb_carfield_llc_cdc_dst_channel;

    localparam int DW = 8;
    localparam int LD = 3;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic [63:0]   src_mem;
    logic [3:0]    wbin;
    logic [3:0]    async_wptr;
    logic [3:0]    async_rptr_o;
    logic [DW-1:0] dst_data_o;
    logic          dst_valid_o;
    logic          dst_ready_i;
    logic          empty_o;

    int checks = 0;
    int passed = 0;

    carfield_llc_cdc_dst_channel #(
        .DataWidth  (DW),
        .LogDepth   (LD),
        .SyncStages (2)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .async_data_i (src_mem),
        .async_wptr_i (async_wptr),
        .async_rptr_o (async_rptr_o),
        .dst_data_o   (dst_data_o),
        .dst_valid_o  (dst_valid_o),
        .dst_ready_i  (dst_ready_i),
        .empty_o      (empty_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] b2g(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [3:0] g2b(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic logic src_full();
        return (wbin - g2b(async_rptr_o)) == 4'd8;
    endfunction

    task automatic src_push(input logic [7:0] v);
        src_mem[wbin[2:0]*8 +: 8] = v;
        wbin       = wbin + 4'd1;
        async_wptr = b2g(wbin);
    endtask

    task automatic src_reset();
        src_mem    = '0;
        wbin       = '0;
        async_wptr = '0;
    endtask

    task automatic do_reset();
        rst_ni      = 1'b0;
        dst_ready_i = 1'b0;
        src_reset();
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
    endtask

    // Valid must hold with stable data across any edge where it was not accepted.
    logic       pv = 1'b0, pr = 1'b0, rst_seen = 1'b0;
    logic [7:0] pd = '0;
    always @(negedge rst_ni) rst_seen = 1'b1;
    always @(negedge clk) begin
        #1;
        if (rst_ni && !rst_seen && pv && !pr) begin
            checks++;
            if (!dst_valid_o || dst_data_o !== pd)
                $display("FAIL stability: valid=%0b data=%h, required valid=1 data=%h", dst_valid_o, dst_data_o, pd);
            else passed++;
        end
        pv = dst_valid_o;
        pd = dst_data_o;
        pr = dst_ready_i;
        rst_seen = 1'b0;
    end

    task automatic test_reset();
        dst_ready_i = 1'b0;
        src_reset();
        rst_ni = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (dst_valid_o !== 1'b0) $display("FAIL reset_valid: got %0b want 0", dst_valid_o); else passed++;
        checks++; if (async_rptr_o !== 4'h0) $display("FAIL reset_rptr: got %h want 0", async_rptr_o); else passed++;
        checks++; if (dst_data_o !== 8'h00) $display("FAIL reset_data: got %h want 00", dst_data_o); else passed++;
        checks++; if (empty_o !== 1'b1) $display("FAIL reset_empty: got %0b want 1", empty_o); else passed++;
        rst_ni = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (dst_valid_o !== 1'b0) $display("FAIL idle_valid: got %0b want 0", dst_valid_o); else passed++;
        checks++; if (empty_o !== 1'b1) $display("FAIL idle_empty: got %0b want 1", empty_o); else passed++;
    endtask

    task automatic test_single_write();
        do_reset();
        src_push(8'hA5);
        repeat (2) @(negedge clk);
        checks++; if (dst_valid_o !== 1'b0) $display("FAIL single_early: valid=%0b after 2 edges, want 0", dst_valid_o); else passed++;
        @(negedge clk);
        checks++; if (dst_valid_o !== 1'b1) $display("FAIL single_valid: got %0b want 1", dst_valid_o); else passed++;
        checks++; if (dst_data_o !== 8'hA5) $display("FAIL single_data: got %h want a5", dst_data_o); else passed++;
        checks++; if (async_rptr_o !== 4'h1) $display("FAIL single_rptr: got %h want 1", async_rptr_o); else passed++;
        checks++; if (empty_o !== 1'b1) $display("FAIL single_empty_loaded: got %0b want 1", empty_o); else passed++;
        dst_ready_i = 1'b1;
        @(negedge clk);
        checks++; if (dst_valid_o !== 1'b0) $display("FAIL single_drop: got %0b want 0", dst_valid_o); else passed++;
        checks++; if (async_rptr_o !== 4'h1) $display("FAIL single_rptr_after: got %h want 1", async_rptr_o); else passed++;
        checks++; if (empty_o !== 1'b1) $display("FAIL single_empty: got %0b want 1", empty_o); else passed++;
        dst_ready_i = 1'b0;
    endtask

    task automatic test_burst();
        int got = 0, first = -1, last = -1;
        do_reset();
        dst_ready_i = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (dst_valid_o) begin
                checks++; if (dst_data_o !== 8'(got)) $display("FAIL burst_data: got %h want %h", dst_data_o, 8'(got)); else passed++;
                if (first < 0) first = cyc;
                last = cyc;
                got++;
            end
            if (cyc < 8) src_push(8'(cyc));
            @(negedge clk);
        end
        checks++; if (got !== 8) $display("FAIL burst_count: got %0d want 8", got); else passed++;
        checks++; if (last - first !== 7) $display("FAIL burst_contiguous: span %0d want 7", last - first); else passed++;
        checks++; if (async_rptr_o !== 4'hC) $display("FAIL burst_rptr: got %h want c", async_rptr_o); else passed++;
        checks++; if (dst_valid_o !== 1'b0) $display("FAIL burst_valid_end: got %0b want 0", dst_valid_o); else passed++;
        checks++; if (empty_o !== 1'b1) $display("FAIL burst_empty: got %0b want 1", empty_o); else passed++;
        dst_ready_i = 1'b0;
    endtask

    task automatic test_backpressure();
        int held_bad = 0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            src_push(8'h30 + 8'(i));
            @(negedge clk);
        end
        repeat (10) begin
            @(negedge clk);
            if (!dst_valid_o || dst_data_o !== 8'h30) held_bad++;
        end
        checks++; if (held_bad !== 0) $display("FAIL bp_hold: %0d bad cycles want 0", held_bad); else passed++;
        checks++; if (dst_data_o !== 8'h30) $display("FAIL bp_data: got %h want 30", dst_data_o); else passed++;
        checks++; if (async_rptr_o !== 4'h1) $display("FAIL bp_rptr: got %h want 1", async_rptr_o); else passed++;
        checks++; if (empty_o !== 1'b0) $display("FAIL bp_empty: got %0b want 0", empty_o); else passed++;
        dst_ready_i = 1'b1;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            checks++; if (dst_valid_o !== 1'b1) $display("FAIL bp_rel_valid: got %0b want 1", dst_valid_o); else passed++;
            checks++; if (dst_data_o !== 8'h30 + 8'(i)) $display("FAIL bp_rel_data: got %h want %h", dst_data_o, 8'h30 + 8'(i)); else passed++;
        end
        @(negedge clk);
        checks++; if (dst_valid_o !== 1'b0) $display("FAIL bp_end_valid: got %0b want 0", dst_valid_o); else passed++;
        checks++; if (async_rptr_o !== 4'h6) $display("FAIL bp_end_rptr: got %h want 6", async_rptr_o); else passed++;
        checks++; if (empty_o !== 1'b1) $display("FAIL bp_end_empty: got %0b want 1", empty_o); else passed++;
        dst_ready_i = 1'b0;
    endtask

    task automatic test_wrap();
        int sent = 0, got = 0, order_err = 0, bad_tr = 0, wraps = 0;
        logic [3:0] prev, cur;
        do_reset();
        prev = async_rptr_o;
        for (int cyc = 0; cyc < 3000 && got < 40; cyc++) begin
            cur = async_rptr_o;
            if (cur !== prev) begin
                if ($countones(cur ^ prev) != 1) bad_tr++;
                if (prev == 4'h8 && cur == 4'h0) wraps++;
            end
            prev = cur;
            dst_ready_i = 1'($urandom_range(0, 1));
            if (dst_valid_o && dst_ready_i) begin
                if (dst_data_o !== 8'h40 + 8'(got)) order_err++;
                got++;
            end
            if (sent < 40 && !src_full()) begin
                src_push(8'h40 + 8'(sent));
                sent++;
            end
            @(negedge clk);
        end
        checks++; if (got !== 40) $display("FAIL wrap_count: got %0d want 40", got); else passed++;
        checks++; if (order_err !== 0) $display("FAIL wrap_order: %0d errors want 0", order_err); else passed++;
        checks++; if (bad_tr !== 0) $display("FAIL wrap_gray_step: %0d multi-bit steps want 0", bad_tr); else passed++;
        checks++; if (wraps !== 2) $display("FAIL wrap_laps: %0d wraps seen want 2", wraps); else passed++;
        checks++; if (async_rptr_o !== 4'hC) $display("FAIL wrap_rptr: got %h want c", async_rptr_o); else passed++;
        dst_ready_i = 1'b1;
        @(negedge clk);
        dst_ready_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        src_push(8'h21); @(negedge clk);
        src_push(8'h22); @(negedge clk);
        src_push(8'h23); @(negedge clk);
        repeat (4) @(negedge clk);
        checks++; if (dst_valid_o !== 1'b1) $display("FAIL mid_pre_valid: got %0b want 1", dst_valid_o); else passed++;
        #2 rst_ni = 1'b0;
        #1;
        checks++; if (dst_valid_o !== 1'b0) $display("FAIL mid_valid: got %0b want 0", dst_valid_o); else passed++;
        checks++; if (async_rptr_o !== 4'h0) $display("FAIL mid_rptr: got %h want 0", async_rptr_o); else passed++;
        checks++; if (empty_o !== 1'b1) $display("FAIL mid_empty: got %0b want 1", empty_o); else passed++;
        checks++; if (dst_data_o !== 8'h00) $display("FAIL mid_data: got %h want 00", dst_data_o); else passed++;
        src_reset();
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        src_push(8'h11);
        repeat (3) @(negedge clk);
        checks++; if (dst_valid_o !== 1'b1 || dst_data_o !== 8'h11) $display("FAIL mid_after: valid=%0b data=%h want 1/11", dst_valid_o, dst_data_o); else passed++;
        checks++; if (async_rptr_o !== 4'h1) $display("FAIL mid_after_rptr: got %h want 1", async_rptr_o); else passed++;
        dst_ready_i = 1'b1;
        @(negedge clk);
        dst_ready_i = 1'b0;
    endtask

    task automatic test_async_ratio(input int src_period);
        int got = 0, order_err = 0, timeout = 0;
        do_reset();
        fork
            begin
                for (int n = 0; n < 24; n++) begin
                    int guard = 0;
                    #(src_period);
                    if (($time % 10) == 5) #1;
                    while (src_full() && guard < 1000) begin
                        #(src_period);
                        if (($time % 10) == 5) #1;
                        guard++;
                    end
                    if (guard >= 1000) timeout++;
                    src_push(8'h80 + 8'(n));
                end
            end
            begin
                for (int cyc = 0; cyc < 2000 && got < 24; cyc++) begin
                    dst_ready_i = ($urandom_range(0, 3) != 0);
                    if (dst_valid_o && dst_ready_i) begin
                        if (dst_data_o !== 8'h80 + 8'(got)) order_err++;
                        got++;
                    end
                    @(negedge clk);
                end
            end
        join
        checks++; if (got !== 24) $display("FAIL ratio%0d_count: got %0d want 24", src_period, got); else passed++;
        checks++; if (order_err !== 0) $display("FAIL ratio%0d_order: %0d errors want 0", src_period, order_err); else passed++;
        checks++; if (timeout !== 0) $display("FAIL ratio%0d_full_wait: %0d expired waits want 0", src_period, timeout); else passed++;
        dst_ready_i = 1'b0;
    endtask

    initial begin
        rst_ni      = 1'b1;
        dst_ready_i = 1'b0;
        src_reset();
        #1;
        test_reset();
        test_single_write();
        test_burst();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_async_ratio(23);
        test_async_ratio(4);
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
